// File: rtl/escritor_texto_if.sv
// Character stream in / text RAM write port out for escritor_texto.
// slave = the writer block, master = the character source / observer side.
interface escritor_texto_if #(
  parameter int ADDR_W = 12
) ();
  logic [6:0]        Char_in;
  logic              Valid;
  logic              Ready;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [6:0]        WrData;
  logic [6:0]        Col;
  logic [4:0]        Fila;

  modport master (
    output Char_in, Valid,
    input  Ready, WrEn, WrAddr, WrData, Col, Fila
  );

  modport slave (
    input  Char_in, Valid,
    output Ready, WrEn, WrAddr, WrData, Col, Fila
  );
endinterface

// File: rtl/escritor_texto.sv
// Text RAM writer: cursor tracking, CR/LF/BS/FF handling and full-screen clear.
// Optional macro CLEAR_ON_RESET_EN: leaving reset runs a full clear before IDLE.
module escritor_texto #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input logic             NCLK,
  input logic             NRST,
  escritor_texto_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LF_WRAP   = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]        FILA_LAST = 5'(ROWS - 1);
  localparam logic [6:0]        SPACE     = 7'h20;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [6:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        fila_q, fila_d;
  logic              accept;

  assign accept = bus.Valid && ready_q;

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cur_d     = cur_q;
    col_d     = col_q;
    fila_d    = fila_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.Char_in >= 7'h20 && bus.Char_in <= 7'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_q;
            wr_data_d = bus.Char_in;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (fila_q == FILA_LAST) begin
                fila_d = '0;
                cur_d  = '0;
              end else begin
                fila_d = fila_q + 5'd1;
                cur_d  = cur_q + ADDR_W'(1);
              end
            end else begin
              col_d = col_q + 7'd1;
              cur_d = cur_q + ADDR_W'(1);
            end
          end else begin
            case (bus.Char_in)
              7'h0D: begin
                col_d = '0;
                cur_d = cur_q - ADDR_W'(col_q);
              end
              7'h0A: begin
                if (fila_q == FILA_LAST) begin
                  fila_d = '0;
                  cur_d  = cur_q - LF_WRAP;
                end else begin
                  fila_d = fila_q + 5'd1;
                  cur_d  = cur_q + ROW_STEP;
                end
              end
              7'h08: begin
                // Erase lands on the cell the cursor moves back to; (0,0) erases in place.
                if (col_q != '0) begin
                  col_d = col_q - 7'd1;
                  cur_d = cur_q - ADDR_W'(1);
                end else if (fila_q != '0) begin
                  col_d  = COL_LAST;
                  fila_d = fila_q - 5'd1;
                  cur_d  = cur_q - ADDR_W'(1);
                end
                wr_en_d   = 1'b1;
                wr_addr_d = cur_d;
                wr_data_d = SPACE;
              end
              7'h0C: begin
                state_d   = ST_CLEAR;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = SPACE;
              end
              default: ;
            endcase
          end
        end
      end

      ST_CLEAR: begin
        // The write address doubles as the sweep counter; a cleared WrEn marks the
        // first sweep cycle straight out of reset.
        if (!wr_en_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = SPACE;
        end else if (wr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          col_d   = '0;
          fila_d  = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          wr_data_d = SPACE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge NCLK) begin
    if (!NRST) begin
`ifdef CLEAR_ON_RESET_EN
      state_q <= ST_CLEAR;
      ready_q <= 1'b0;
`else
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
`endif
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cur_q     <= '0;
      col_q     <= '0;
      fila_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cur_q     <= cur_d;
      col_q     <= col_d;
      fila_q    <= fila_d;
    end
  end

  assign bus.Ready  = ready_q;
  assign bus.WrEn   = wr_en_q;
  assign bus.WrAddr = wr_addr_q;
  assign bus.WrData = wr_data_q;
  assign bus.Col    = col_q;
  assign bus.Fila   = fila_q;
endmodule

// File: tb/tb_escritor_texto.sv
// Bench for escritor_texto: directed scenarios plus random traffic against a
// screen-position reference model (linear cell index, div/mod arithmetic).
module tb_escritor_texto;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int TOTAL  = COLS * ROWS;

  logic NCLK = 1'b0;
  logic NRST = 1'b0;

  escritor_texto_if #(.ADDR_W(ADDR_W)) bus ();

  escritor_texto #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .NCLK (NCLK),
    .NRST (NRST),
    .bus  (bus)
  );

  always #5 NCLK = ~NCLK;

  int total = 0;
  int bad   = 0;

  // Reference model: cursor position and clear-sweep progress
  int m_col = 0;
  int m_row = 0;
  int m_idx = 0;
`ifdef CLEAR_ON_RESET_EN
  bit m_clr = 1'b1;
`else
  bit m_clr = 1'b0;
`endif

  // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
  task automatic cycle(input bit v, input logic [6:0] code, input bit rst_n);
    bit                exp_wen;
    logic [ADDR_W-1:0] exp_addr;
    logic [6:0]        exp_data;
    int                pos;
    @(negedge NCLK);
    bus.Valid   = v;
    bus.Char_in = code;
    NRST        = rst_n;
    total++;
    if (bus.Ready !== !m_clr) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want %b", bus.Ready, !m_clr);
    end
    exp_wen  = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (!rst_n) begin
      m_col = 0;
      m_row = 0;
`ifdef CLEAR_ON_RESET_EN
      m_clr = 1'b1;
      m_idx = 0;
`else
      m_clr = 1'b0;
`endif
    end else if (m_clr) begin
      if (m_idx < TOTAL) begin
        exp_wen  = 1'b1;
        exp_addr = ADDR_W'(m_idx);
        exp_data = 7'h20;
        m_idx++;
      end else begin
        m_clr = 1'b0;
        m_col = 0;
        m_row = 0;
      end
    end else if (v) begin
      pos = m_row * COLS + m_col;
      if (code >= 7'h20 && code <= 7'h7E) begin
        exp_wen  = 1'b1;
        exp_addr = ADDR_W'(pos);
        exp_data = code;
        pos      = (pos + 1) % TOTAL;
        m_row    = pos / COLS;
        m_col    = pos % COLS;
      end else if (code == 7'h0D) begin
        m_col = 0;
      end else if (code == 7'h0A) begin
        m_row = (m_row + 1) % ROWS;
      end else if (code == 7'h08) begin
        if (pos > 0) pos--;
        m_row    = pos / COLS;
        m_col    = pos % COLS;
        exp_wen  = 1'b1;
        exp_addr = ADDR_W'(pos);
        exp_data = 7'h20;
      end else if (code == 7'h0C) begin
        exp_wen  = 1'b1;
        exp_addr = '0;
        exp_data = 7'h20;
        m_clr    = 1'b1;
        m_idx    = 1;
      end
    end
    @(posedge NCLK);
    #1;
    total++;
    if (bus.WrEn !== exp_wen) begin
      bad++;
      $display("FAIL wr_en: got %b want %b", bus.WrEn, exp_wen);
    end
    if (exp_wen || !rst_n) begin
      total++;
      if (bus.WrAddr !== exp_addr || bus.WrData !== exp_data) begin
        bad++;
        $display("FAIL wr_bus: got addr=%0d data=%h want addr=%0d data=%h",
                 bus.WrAddr, bus.WrData, exp_addr, exp_data);
      end
    end
    total++;
    if (bus.Ready !== !m_clr) begin
      bad++;
      $display("FAIL ready_after_edge: got %b want %b", bus.Ready, !m_clr);
    end
    if (!m_clr || !rst_n) begin
      total++;
      if (bus.Col !== 7'(m_col) || bus.Fila !== 5'(m_row)) begin
        bad++;
        $display("FAIL cursor: got (%0d,%0d) want (%0d,%0d)", bus.Col, bus.Fila, m_col, m_row);
      end
    end
  endtask

  task automatic drain_clear();
    while (m_clr) cycle(1'b0, 7'h00, 1'b1);
  endtask

  task automatic move_to(input int c, input int r);
    cycle(1'b1, 7'h0D, 1'b1);
    while (m_row != r) cycle(1'b1, 7'h0A, 1'b1);
    for (int i = 0; i < c; i++) cycle(1'b1, 7'h2E, 1'b1);
  endtask

  task automatic test_reset();
    logic exp_rdy;
`ifdef CLEAR_ON_RESET_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    cycle(1'b1, 7'h5A, 1'b0);
    cycle(1'b1, 7'h5A, 1'b0);
    total++;
    if (bus.WrEn !== 1'b0 || bus.WrAddr !== '0 || bus.Ready !== exp_rdy) begin
      bad++;
      $display("FAIL reset_state: got wen=%b addr=%0d rdy=%b want wen=0 addr=0 rdy=%b",
               bus.WrEn, bus.WrAddr, bus.Ready, exp_rdy);
    end
    cycle(1'b0, 7'h00, 1'b1);
    drain_clear();
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 7'h41, 1'b1);
    total++;
    if (bus.WrAddr !== 12'd0 || bus.WrData !== 7'h41) begin
      bad++;
      $display("FAIL b2b_first: got addr=%0d data=%h want addr=0 data=41", bus.WrAddr, bus.WrData);
    end
    cycle(1'b1, 7'h42, 1'b1);
    total++;
    if (bus.WrEn !== 1'b1 || bus.WrAddr !== 12'd1 || bus.WrData !== 7'h42 ||
        bus.Col !== 7'd2 || bus.Fila !== 5'd0) begin
      bad++;
      $display("FAIL b2b_second: got wen=%b addr=%0d data=%h col=%0d fila=%0d want 1 1 42 2 0",
               bus.WrEn, bus.WrAddr, bus.WrData, bus.Col, bus.Fila);
    end
  endtask

  task automatic test_wrap();
    move_to(79, 0);
    cycle(1'b1, 7'h58, 1'b1);
    total++;
    if (bus.WrAddr !== 12'd79 || bus.Col !== 7'd0 || bus.Fila !== 5'd1) begin
      bad++;
      $display("FAIL wrap_row: got addr=%0d cursor=(%0d,%0d) want 79 (0,1)", bus.WrAddr, bus.Col, bus.Fila);
    end
    move_to(79, 29);
    cycle(1'b1, 7'h58, 1'b1);
    total++;
    if (bus.WrAddr !== 12'd2399 || bus.Col !== 7'd0 || bus.Fila !== 5'd0) begin
      bad++;
      $display("FAIL wrap_screen: got addr=%0d cursor=(%0d,%0d) want 2399 (0,0)", bus.WrAddr, bus.Col, bus.Fila);
    end
  endtask

  task automatic test_cr_lf();
    move_to(5, 2);
    cycle(1'b1, 7'h0D, 1'b1);
    cycle(1'b1, 7'h0A, 1'b1);
    total++;
    if (bus.WrEn !== 1'b0 || bus.Col !== 7'd0 || bus.Fila !== 5'd3) begin
      bad++;
      $display("FAIL cr_lf: got wen=%b cursor=(%0d,%0d) want 0 (0,3)", bus.WrEn, bus.Col, bus.Fila);
    end
    cycle(1'b1, 7'h61, 1'b1);
    total++;
    if (bus.WrAddr !== 12'd240) begin
      bad++;
      $display("FAIL cr_lf_addr: got %0d want 240", bus.WrAddr);
    end
  endtask

  task automatic test_bs();
    move_to(0, 1);
    cycle(1'b1, 7'h08, 1'b1);
    total++;
    if (bus.WrAddr !== 12'd79 || bus.WrData !== 7'h20 || bus.Col !== 7'd79 || bus.Fila !== 5'd0) begin
      bad++;
      $display("FAIL bs_row: got addr=%0d data=%h cursor=(%0d,%0d) want 79 20 (79,0)",
               bus.WrAddr, bus.WrData, bus.Col, bus.Fila);
    end
    move_to(0, 0);
    cycle(1'b1, 7'h08, 1'b1);
    total++;
    if (bus.WrEn !== 1'b1 || bus.WrAddr !== 12'd0 || bus.Col !== 7'd0 || bus.Fila !== 5'd0) begin
      bad++;
      $display("FAIL bs_origin: got wen=%b addr=%0d cursor=(%0d,%0d) want 1 0 (0,0)",
               bus.WrEn, bus.WrAddr, bus.Col, bus.Fila);
    end
  endtask

  task automatic test_ignored();
    logic [6:0] codes [5];
    codes = '{7'h00, 7'h07, 7'h1B, 7'h1F, 7'h7F};
    move_to(7, 4);
    foreach (codes[i]) cycle(1'b1, codes[i], 1'b1);
    total++;
    if (bus.WrEn !== 1'b0 || bus.Col !== 7'd7 || bus.Fila !== 5'd4) begin
      bad++;
      $display("FAIL ignored: got wen=%b cursor=(%0d,%0d) want 0 (7,4)", bus.WrEn, bus.Col, bus.Fila);
    end
  endtask

  task automatic test_clear();
    int n;
    move_to(3, 4);
    cycle(1'b1, 7'h0C, 1'b1);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b1, 7'h51, 1'b1);
      if (bus.Ready === 1'b0) n++;
      else break;
    end
    total++;
    if (n != TOTAL || bus.Col !== 7'd0 || bus.Fila !== 5'd0) begin
      bad++;
      $display("FAIL clear_len: got busy=%0d cursor=(%0d,%0d) want %0d (0,0)", n, bus.Col, bus.Fila, TOTAL);
    end
    cycle(1'b0, 7'h00, 1'b1);
  endtask

  task automatic test_reset_mid_clear();
    logic exp_rdy;
`ifdef CLEAR_ON_RESET_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    cycle(1'b1, 7'h0C, 1'b1);
    while (m_idx < 1001) cycle(1'b0, 7'h00, 1'b1);
    cycle(1'b1, 7'h51, 1'b0);
    total++;
    if (bus.WrEn !== 1'b0 || bus.Ready !== exp_rdy) begin
      bad++;
      $display("FAIL reset_mid_clear: got wen=%b rdy=%b want 0 %b", bus.WrEn, bus.Ready, exp_rdy);
    end
    cycle(1'b0, 7'h00, 1'b1);
    drain_clear();
  endtask

  task automatic test_random();
    logic [6:0] junk [7];
    logic [6:0] code;
    int         r;
    bit         v;
    junk = '{7'h00, 7'h01, 7'h07, 7'h09, 7'h1B, 7'h1F, 7'h7F};
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (r < 140)      code = 7'($urandom_range(32, 126));
      else if (r < 152) code = 7'h0D;
      else if (r < 166) code = 7'h0A;
      else if (r < 184) code = 7'h08;
      else if (r < 198) code = junk[$urandom_range(0, 6)];
      else              code = 7'h0C;
      cycle(v, code, 1'b1);
    end
    drain_clear();
  endtask

  initial begin
    bus.Valid   = 1'b0;
    bus.Char_in = 7'h00;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_cr_lf();
    test_bs();
    test_ignored();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/escritor_texto.md
# escritor_texto

- Writer side of the on-screen text path: accepts a stream of 7-bit character codes and writes them into the text RAM that the character ROM pixel path reads to draw glyphs.
- Tracks a cursor (column/row), interprets a small set of control codes, and clears the whole buffer to spaces on request.
- Sits between the character source (keyboard/UART decoder, test pattern logic) and the write port of the dual-port text RAM.

## Interface

Parameters:
- COLS, 80, character columns per row
- ROWS, 30, character rows
- ADDR_W, 12, text RAM address width; COLS*ROWS ≤ 2^ADDR_W

Ports:
- NCLK  in  1  system clock, all logic on rising edge
- NRST  in  1  reset, synchronous, active-low
- Char_in  in  7  character code (ASCII 0x00-0x7F)
- Valid  in  1  Char_in valid
- Ready  out  1  block can accept; transfer when Valid && Ready
- WrEn  out  1  text RAM write strobe, one cycle per write
- WrAddr  out  ADDR_W  text RAM address = Fila*COLS + Col
- WrData  out  7  character code written
- Col  out  7  cursor column, 0..COLS-1
- Fila  out  5  cursor row, 0..ROWS-1

## Operation

States:
- IDLE: Ready=1.
- CLEAR: Ready=0.

Accepted code handling in IDLE (one code per cycle, back-to-back allowed):
- Printable 0x20-0x7E:
  - Next cycle: WrEn=1, WrData=code, WrAddr=address of the cursor before the advance.
  - Cursor advances: Col+1.
  - At Col=COLS-1: Col→0, Fila+1.
  - At Fila=ROWS-1 and Col=COLS-1: wraps to (0,0). No scrolling.
- 0x0D (CR): Col→0. No write.
- 0x0A (LF): Fila+1, wrapping ROWS-1→0. Col unchanged. No write.
- 0x08 (BS):
  - Cursor moves back one cell: Col-1; if Col=0 and Fila>0, Col→COLS-1 and Fila-1.
  - At (0,0): cursor stays at (0,0).
  - Next cycle writes 0x20 at the new cursor address.
- 0x0C (FF): enter CLEAR.
- Any other code (0x00-0x1F not listed, 0x7F): ignored, no write, cursor unchanged.

CLEAR:
- Ready drops in the cycle after FF is accepted.
- Writes 0x20 to addresses 0 .. COLS*ROWS-1, one per cycle, ascending, WrEn held high.
- After the last address: cursor set to (0,0), return to IDLE.
- Duration: exactly COLS*ROWS write cycles.

Reset (NRST=0 sampled on an NCLK edge, including mid-CLEAR):
- Outputs: WrEn=0, WrAddr=0, WrData=0, Col=0, Fila=0.
- Ready=1, state IDLE (see Configuration).
- Any pending write is dropped.

Arithmetic and widths:
- Keep a linear address register alongside Col/Fila; no run-time multiplier.
- Address rules: +1 on advance, -1 on BS, +COLS on LF modulo COLS*ROWS, -Col on CR.
- WrAddr never exceeds COLS*ROWS-1.

## Timing

- Write latency: accept edge N → WrEn/WrAddr/WrData valid for the cycle after edge N; all outputs are registered.
- Col/Fila update on the same edge that registers the write.
- Throughput: 1 printable code/cycle in IDLE.
- Ready is a registered state decode, independent of Valid.
- Valid while Ready=0: no transfer; the source must hold Char_in.
- FF: Ready=0 from the cycle after acceptance, for COLS*ROWS cycles; first clear write appears the cycle after acceptance.
- A printable code accepted in the same cycle as FF is not possible (one transfer per cycle).
- Simultaneous NRST=0 and Valid: reset wins; the code is dropped.

## Configuration

Macro CLEAR_ON_RESET_EN:
- Defined: leaving reset enters CLEAR instead of IDLE.
  - Ready=0 and the full buffer is written to 0x20 (COLS*ROWS cycles), then IDLE.
  - Output reset values above still apply during the reset cycle.
- Undefined: leaving reset enters IDLE with Ready=1; RAM contents are untouched.

## Test plan

- Reset, then 'A'(0x41), 'B'(0x42) back-to-back → WrEn two consecutive cycles, (addr 0, 0x41) then (addr 1, 0x42); Col=2, Fila=0.
- Cursor at (79,0), send 0x58 → write at addr 79; cursor (0,1). At (79,29), send 0x58 → write at addr 2399; cursor (0,0).
- Cursor (5,2), send CR then LF → no writes; cursor (0,3), next printable writes addr 240.
- Cursor (0,1), send BS → write 0x20 at addr 79, cursor (79,0); at (0,0), BS → write 0x20 at addr 0, cursor (0,0).
- Send FF → Ready=0 for 2400 cycles, addresses 0..2399 written with 0x20 in order, then Ready=1, cursor (0,0); Valid held during CLEAR causes no transfer.
- Assert NRST=0 at clear address 1000 → next cycle WrEn=0, Ready=1 (macro undefined) or restart of CLEAR at addr 0 (CLEAR_ON_RESET_EN defined).
